microwave_timer_ctrl: RTL

//  Cook-timer controller for the microwave. Sequences the 1 Hz timebase: an internal prescaler

---
 rtl/microwave_timer_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer controller: BCD mm:ss countdown, 1 Hz prescaler and magnetron gating
// driven by keypad digits and start/pause/clear/door events.
module microwave_timer_ctrl #(
    parameter int unsigned DIV = 100
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COOK  = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    state_t        cur_state, nxt_state;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;
    logic [3:0]    dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
    logic          done_nxt;
    logic          tick;
    logic          time_zero;
    logic          last_sec;

    assign state     = cur_state;
    assign tick      = (presc == PW'(DIV - 1));
    assign time_zero = (min_t == 4'd0) && (min_o == 4'd0) && (sec_t == 4'd0) && (sec_o == 4'd0);
    assign last_sec  = (min_t == 4'd0) && (min_o == 4'd0) && (sec_t == 4'd0) && (sec_o == 4'd1);

    // One-second BCD decrement; seconds borrow from minutes and reload 59
    always_comb begin
        dec_min_t = min_t;
        dec_min_o = min_o;
        dec_sec_t = sec_t;
        dec_sec_o = sec_o;
        if (sec_o != 4'd0) begin
            dec_sec_o = sec_o - 4'd1;
        end else if (sec_t != 4'd0) begin
            dec_sec_o = 4'd9;
            dec_sec_t = sec_t - 4'd1;
        end else begin
            dec_sec_o = 4'd9;
            dec_sec_t = 4'd5;
            if (min_o != 4'd0) begin
                dec_min_o = min_o - 4'd1;
            end else begin
                dec_min_o = 4'd9;
                dec_min_t = min_t - 4'd1;
            end
        end
    end

    // Next-state, time and pulse logic; event priority door > clear > pause > start > digit
    always_comb begin
        nxt_state = cur_state;
        presc_nxt = '0;
        min_t_nxt = min_t;
        min_o_nxt = min_o;
        sec_t_nxt = sec_t;
        sec_o_nxt = sec_o;
        done_nxt  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (clear) begin
                    {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
                end else if (start && door_closed && !time_zero) begin
                    nxt_state = S_COOK;
                end else if (digit_valid && (digit <= 4'd9)) begin
                    {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = {min_o, sec_t, sec_o, digit};
                end
            end
            S_COOK: begin
                if (!door_closed) begin
                    nxt_state = S_PAUSE;
                end else if (clear) begin
                    nxt_state = S_IDLE;
                    {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
                end else if (pause) begin
                    nxt_state = S_PAUSE;
                end else if (tick) begin
                    {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} =
                        {dec_min_t, dec_min_o, dec_sec_t, dec_sec_o};
                    if (last_sec) begin
                        nxt_state = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    nxt_state = S_IDLE;
                    {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
                end else if (start && door_closed) begin
                    nxt_state = S_COOK;
                end
            end
            S_DONE: begin
                // start alone leaves the finished display up; it never restarts cooking
                if (!door_closed || clear) begin
                    nxt_state = S_IDLE;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
            presc     <= '0;
            min_t     <= 4'd0;
            min_o     <= 4'd0;
            sec_t     <= 4'd0;
            sec_o     <= 4'd0;
            mag_on    <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            presc     <= presc_nxt;
            min_t     <= min_t_nxt;
            min_o     <= min_o_nxt;
            sec_t     <= sec_t_nxt;
            sec_o     <= sec_o_nxt;
            mag_on    <= (nxt_state == S_COOK);
            done      <= done_nxt;
        end
    end

endmodule
